// File: rtl/cordic_engine.sv
// rtl/cordic_engine.sv - folded CORDIC engine, rotation and vectoring modes, saturated x/y/z outputs
module cordic_engine #(
    parameter int WORD_LENGTH  = 21,
    parameter int FRAC_BITS    = 19,
    parameter int N_ITERATIONS = 17,
    parameter int GUARD_BITS   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [WORD_LENGTH-1:0] in_x,
    input  logic [WORD_LENGTH-1:0] in_y,
    input  logic [WORD_LENGTH-1:0] in_z,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] out_x,
    output logic [WORD_LENGTH-1:0] out_y,
    output logic [WORD_LENGTH-1:0] out_z,
    output logic                   busy
);

    localparam int IW          = WORD_LENGTH + GUARD_BITS;
    localparam int ROUND_SHIFT = 30 - FRAC_BITS;
    localparam longint ROUND_HALF = (longint'(1) << ROUND_SHIFT) >>> 1;
    localparam logic [4:0] LAST_ITER = 5'(N_ITERATIONS - 1);

    if (FRAC_BITS < 8 || FRAC_BITS > 30) begin : g_bad_frac_bits
        $error("cordic_engine: FRAC_BITS must be within 8..30");
    end
    if (N_ITERATIONS < 1 || N_ITERATIONS > 24) begin : g_bad_n_iterations
        $error("cordic_engine: N_ITERATIONS must be within 1..24");
    end

    // atan(2^-i) at 30 fractional bits, rounded half away from zero to FRAC_BITS below
    localparam longint ATAN_Q30 [24] = '{
        843314857, 497837829, 263043837, 133525159, 67021687, 33543516,
        16775851,  8388437,   4194283,   2097149,   1048576,  524288,
        262144,    131072,    65536,     32768,     16384,    8192,
        4096,      2048,      1024,      512,       256,      128
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [4:0]            r_iter;
    logic                  r_mode;
    logic signed [IW-1:0]  r_x;
    logic signed [IW-1:0]  r_y;
    logic signed [IW-1:0]  r_z;

    logic                  w_load;
    logic                  w_step;
    logic                  w_last;
    logic                  w_d_pos;
    logic signed [IW-1:0]  w_atan_rom [24];
    logic signed [IW-1:0]  w_atan;
    logic signed [IW-1:0]  w_xs;
    logic signed [IW-1:0]  w_ys;
    logic signed [IW-1:0]  w_x_next;
    logic signed [IW-1:0]  w_y_next;
    logic signed [IW-1:0]  w_z_next;
    logic signed [IW-1:0]  w_x_load;
    logic signed [IW-1:0]  w_y_load;
    logic signed [IW-1:0]  w_z_load;

    for (genvar k = 0; k < 24; k++) begin : g_atan_rom
        localparam longint RND = (ATAN_Q30[k] + ROUND_HALF) >>> ROUND_SHIFT;
        assign w_atan_rom[k] = RND[IW-1:0];
    end

    function automatic logic [WORD_LENGTH-1:0] sat(input logic signed [IW-1:0] v);
        logic [IW-WORD_LENGTH:0] top;
        top = v[IW-1:WORD_LENGTH-1];
        if ((&top) || !(|top)) begin
            return v[WORD_LENGTH-1:0];
        end else if (v[IW-1]) begin
            return {1'b1, {(WORD_LENGTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WORD_LENGTH-1){1'b1}}};
        end
    endfunction

    assign w_x_load = IW'($signed(in_x));
    assign w_y_load = IW'($signed(in_y));
    assign w_z_load = in_mode ? '0 : IW'($signed(in_z));

    assign w_last  = (r_iter == LAST_ITER);
    assign w_atan  = w_atan_rom[r_iter];
    assign w_xs    = r_x >>> r_iter;
    assign w_ys    = r_y >>> r_iter;
    // d = +1: rotation drives z toward zero, vectoring drives y toward zero
    assign w_d_pos = r_mode ? r_y[IW-1] : ~r_z[IW-1];

    assign w_x_next = w_d_pos ? (r_x - w_ys)   : (r_x + w_ys);
    assign w_y_next = w_d_pos ? (r_y + w_xs)   : (r_y - w_xs);
    assign w_z_next = w_d_pos ? (r_z - w_atan) : (r_z + w_atan);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        w_load       = 1'b1;
                        w_state_next = S_RUN;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_iter  <= '0;
            r_mode  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_mode <= in_mode;
                r_iter <= '0;
                r_x    <= w_x_load;
                r_y    <= w_y_load;
                r_z    <= w_z_load;
            end else if (w_step) begin
                r_x    <= w_x_next;
                r_y    <= w_y_next;
                r_z    <= w_z_next;
                r_iter <= w_last ? 5'd0 : r_iter + 5'd1;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN);
    assign out_x     = sat(r_x);
    assign out_y     = sat(r_y);
    assign out_z     = sat(r_z);

endmodule

// File: tb/tb_cordic_engine.sv
// tb/tb_cordic_engine.sv - directed bench for cordic_engine with a real-arithmetic reference model
module tb_cordic_engine;

    localparam int WL = 21;
    localparam int FB = 19;
    localparam int NI = 17;
    localparam int GB = 2;
    localparam int IW = WL + GB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [WL-1:0] in_x;
    logic [WL-1:0] in_y;
    logic [WL-1:0] in_z;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] out_x;
    logic [WL-1:0] out_y;
    logic [WL-1:0] out_z;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        longint x;
        longint y;
        longint z;
        int     acc;
    } exp_t;

    exp_t exp_q[$];
    bit   front_seen = 1'b0;

    cordic_engine #(
        .WORD_LENGTH (WL),
        .FRAC_BITS   (FB),
        .N_ITERATIONS(NI),
        .GUARD_BITS  (GB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_z     (in_z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_z    (out_z),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp, input longint tol);
        n_checks++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at t=%0t", name, act, exp, tol, $time);
        end
    endtask

    function automatic longint wrap_iw(input longint v);
        longint m;
        m = v & ((longint'(1) << IW) - 1);
        if (m >= (longint'(1) << (IW - 1))) m = m - (longint'(1) << IW);
        return m;
    endfunction

    function automatic longint sat_wl(input longint v);
        longint hi;
        hi = (longint'(1) << (WL - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    // CORDIC micro-rotations in plain integer arithmetic; angles from $atan, not a stored table
    task automatic model(input bit m, input longint x0, input longint y0, input longint z0,
                         output longint ox, output longint oy, output longint oz);
        longint x, y, z, nx, ny, a, d;
        x = x0;
        y = y0;
        z = m ? 0 : z0;
        for (int i = 0; i < NI; i++) begin
            a = longint'($floor($atan(2.0 ** (-i)) * (2.0 ** FB) + 0.5));
            if (m) d = (y < 0) ? 1 : -1;
            else   d = (z >= 0) ? 1 : -1;
            nx = wrap_iw(x - d * (y >>> i));
            ny = wrap_iw(y + d * (x >>> i));
            z  = wrap_iw(z - d * a);
            x  = nx;
            y  = ny;
        end
        ox = sat_wl(x);
        oy = sat_wl(y);
        oz = sat_wl(z);
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            exp_q.delete();
            front_seen = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0, 0);
                end else begin
                    if (!front_seen) begin
                        chk("latency_edges", cyc - exp_q[0].acc, NI + 1, 0);
                        front_seen = 1'b1;
                    end
                    chk("model_out_x", longint'($signed(out_x)), exp_q[0].x, 0);
                    chk("model_out_y", longint'($signed(out_y)), exp_q[0].y, 0);
                    chk("model_out_z", longint'($signed(out_z)), exp_q[0].z, 0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        front_seen = 1'b0;
                    end else begin
                        chk("in_ready_under_backpressure", in_ready, 0, 0);
                    end
                end
            end
            if (in_valid && in_ready) begin
                model(in_mode, longint'($signed(in_x)), longint'($signed(in_y)),
                      longint'($signed(in_z)), e.x, e.y, e.z);
                e.acc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_op(input bit m, input longint x, input longint y, input longint z);
        int t;
        in_mode  = m;
        in_x     = x[WL-1:0];
        in_y     = y[WL-1:0];
        in_z     = z[WL-1:0];
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 60) begin
            tick();
            t++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!out_valid && t < 100) begin
            tick();
            t++;
        end
        chk(name, out_valid, 1, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint mx, my, mz;
        bit     seen;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        out_ready = 1'b0;

        // pin the reference model itself against hand-derived values
        model(0, 318375, 0, 262144, mx, my, mz);
        chk("pin_model_cos", mx, 460105, 8);
        chk("pin_model_sin", my, 251358, 8);
        model(1, 262144, 262144, 0, mx, my, mz);
        chk("pin_model_mag", mx, 610502, 8);
        chk("pin_model_atan", mz, 411775, 8);

        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        chk("reset_in_ready", in_ready, 1, 0);
        chk("reset_out_valid", out_valid, 0, 0);
        chk("reset_busy", busy, 0, 0);
        chk("reset_out_x", out_x, 0, 0);
        chk("reset_out_y", out_y, 0, 0);
        chk("reset_out_z", out_z, 0, 0);

        // rotation: cos/sin of 0.5 rad
        out_ready = 1'b1;
        start_op(0, 318375, 0, 262144);
        chk("rot_busy", busy, 1, 0);
        chk("rot_in_ready_run", in_ready, 0, 0);
        wait_valid("rot_valid");
        chk("rot_cos", longint'($signed(out_x)), 460105, 8);
        chk("rot_sin", longint'($signed(out_y)), 251358, 8);
        chk("rot_z", longint'($signed(out_z)), 0, 8);
        tick();
        chk("rot_release_valid", out_valid, 0, 0);
        chk("rot_release_ready", in_ready, 1, 0);

        // vectoring: in_z must be ignored
        start_op(1, 262144, 262144, 12345);
        wait_valid("vec_valid");
        chk("vec_mag", longint'($signed(out_x)), 610502, 8);
        chk("vec_y", longint'($signed(out_y)), 0, 8);
        chk("vec_atan", longint'($signed(out_z)), 411775, 8);
        tick();

        // backpressure then back-to-back accept
        out_ready = 1'b0;
        start_op(0, 318375, 0, 262144);
        wait_valid("bp_valid");
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1, 0);
            chk("bp_hold_in_ready", in_ready, 0, 0);
            chk("bp_hold_sin", longint'($signed(out_y)), 251358, 8);
        end
        in_mode   = 1'b0;
        in_x      = 21'd318375;
        in_y      = '0;
        in_z      = -21'sd262144;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready, 1, 0);
        tick();
        in_valid = 1'b0;
        chk("b2b_busy", busy, 1, 0);
        chk("b2b_out_valid_drop", out_valid, 0, 0);
        wait_valid("b2b_valid");
        chk("b2b_cos", longint'($signed(out_x)), 460105, 8);
        chk("b2b_neg_sin", longint'($signed(out_y)), -251358, 8);
        tick();

        // saturation: magnitude exceeds the output range
        start_op(1, 1048575, 1048575, 0);
        wait_valid("sat_valid");
        chk("sat_out_x_clamped", longint'($signed(out_x)), 1048575, 0);
        tick();

        // asynchronous reset mid-operation
        start_op(0, 318375, 0, 100000);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0, 0);
        chk("abort_busy", busy, 0, 0);
        chk("abort_out_x", out_x, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("abort_in_ready", in_ready, 1, 0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_emit", seen, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
